// File: rtl/mem_write_dma_if.sv
// Bus interfaces for mem_write_dma: command, data stream, status stream
// and the AXI4 memory-mapped master port.
interface axis_mem_cmd;
  logic        valid;
  logic        ready;
  logic [63:0] address;
  logic [31:0] length;
  modport master (output valid, address, length, input ready);
  modport slave  (input valid, address, length, output ready);
endinterface

interface axi_stream #(parameter int WIDTH = 512);
  logic               valid;
  logic               ready;
  logic               last;
  logic [WIDTH-1:0]   data;
  logic [WIDTH/8-1:0] keep;
  modport master (output valid, last, data, keep, input ready);
  modport slave  (input valid, last, data, keep, output ready);
endinterface

interface axis_mem_status;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

interface axi_mm #(parameter int ADDR_W = 64, parameter int DATA_W = 512, parameter int ID_W = 4);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid, arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/mem_write_dma.sv
// Write DMA: one command + 512b stream -> 4KB-safe AXI4 INCR bursts,
// B responses folded into one 8b completion status per command.
module mem_write_dma #(
  parameter int         MAX_BURST_BEATS = 64,
  parameter int         MAX_OUTSTANDING = 8,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic          aclk,
  input  logic          aresetn,
  axis_mem_cmd.slave    s_axis_cmd,
  axi_stream.slave      s_axis_data,
  axis_mem_status.master m_axis_status,
  axi_mm.master         m_axi
);

  typedef enum logic [2:0] {IDLE, AW, DATA, WAIT_B, STATUS} state_t;

  state_t      state, state_nxt;
  logic [63:0] addr;
  logic [32:0] remaining;
  logic [8:0]  burst;
  logic [8:0]  beat_cnt;
  logic [4:0]  outstanding;
  logic        berr, mismatch, run;

  logic [32:0] beats_total, span_4k, cand;
  logic [8:0]  burst_c;
  logic        cmd_hs, aw_hs, w_hs, b_hs, wlast_c, final_beat;

  // Burst size: limited by remaining beats, the burst cap and the 4KB page edge
  always_comb begin
    beats_total = ({1'b0, s_axis_cmd.length} + 33'd63) >> 6;
    span_4k     = 33'd64 - 33'(addr[11:6]);
    cand        = remaining;
    if (33'(MAX_BURST_BEATS) < cand) cand = 33'(MAX_BURST_BEATS);
    if (span_4k < cand) cand = span_4k;
    burst_c     = cand[8:0];
  end

  assign cmd_hs     = s_axis_cmd.valid & s_axis_cmd.ready;
  assign aw_hs      = m_axi.awvalid & m_axi.awready;
  assign w_hs       = m_axi.wvalid & m_axi.wready;
  assign b_hs       = m_axi.bvalid & m_axi.bready;
  assign wlast_c    = (state == DATA) && (beat_cnt == burst - 9'd1);
  assign final_beat = wlast_c && (remaining == 33'(burst));

  assign s_axis_cmd.ready = run && (state == IDLE);

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = addr;
  assign m_axi.awlen   = (state == AW) ? 8'(burst_c - 9'd1) : 8'd0;
  assign m_axi.awsize  = 3'b110;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  // awvalid can only rise here: outstanding never grows while waiting in AW
  assign m_axi.awvalid = (state == AW) && (outstanding < 5'(MAX_OUTSTANDING));

  assign m_axi.wvalid      = (state == DATA) & s_axis_data.valid;
  assign m_axi.wdata       = (state == DATA) ? s_axis_data.data : '0;
  assign m_axi.wstrb       = (state == DATA) ? s_axis_data.keep : '0;
  assign m_axi.wlast       = wlast_c;
  assign s_axis_data.ready = (state == DATA) & m_axi.wready;

  assign m_axi.bready = (outstanding != 5'd0);

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = '0;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = 3'b000;
  assign m_axi.arburst = 2'b00;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b1;

  assign m_axis_status.valid = (state == STATUS);
  assign m_axis_status.data  = (state == STATUS) ? {5'b0, mismatch, berr, 1'b1} : 8'd0;

  logic unused;
  assign unused = ^{s_axis_cmd.address[5:0], cand[32:9], m_axi.bid, m_axi.arready,
                    m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.rvalid};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cmd_hs) state_nxt = (s_axis_cmd.length == 32'd0) ? STATUS : AW;
      AW:     if (aw_hs) state_nxt = DATA;
      DATA:   if (w_hs && wlast_c) state_nxt = (remaining == 33'(burst)) ? WAIT_B : AW;
      WAIT_B: if ((outstanding == 5'd0) || (outstanding == 5'd1 && b_hs)) state_nxt = STATUS;
      STATUS: if (m_axis_status.ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      burst       <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      berr        <= 1'b0;
      mismatch    <= 1'b0;
      run         <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (cmd_hs) begin
        addr      <= {s_axis_cmd.address[63:6], 6'b0};
        remaining <= beats_total;
        berr      <= 1'b0;
        mismatch  <= 1'b0;
      end
      if (aw_hs) begin
        burst    <= burst_c;
        beat_cnt <= '0;
      end
      if (w_hs) begin
        if (s_axis_data.last != final_beat) mismatch <= 1'b1;
        if (wlast_c) begin
          addr      <= addr + {49'b0, burst, 6'b0};
          remaining <= remaining - 33'(burst);
          beat_cnt  <= '0;
        end else begin
          beat_cnt <= beat_cnt + 9'd1;
        end
      end
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
      if (b_hs && (m_axi.bresp != 2'b00)) berr <= 1'b1;
    end
  end

endmodule
